uart_tx_drain: RTL and testbench

//   Consumer end of the byte ring buffer: pops bytes via the buffer's read-side

---
 rtl/uart_tx_drain_pkg.sv | 26 ++
 rtl/uart_tx_drain_if.sv | 19 +
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_tx_drain.sv | 113 +++++++++++
 tb/tb_uart_tx_drain.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_drain_pkg
// Brief  : Shared constants for the ring-buffer UART transmit drain:
//          default bit timing and FSM state encodings (3-bit binary).
// Rev    : 1.0  initial release
// ============================================================================
package uart_tx_drain_pkg;

  // Default bit timing: 100 MHz system clock, 115200 baud
  localparam int c_uart_clk_per_bit = 868;
  localparam int c_len_uart_cnt     = 16;

  // Byte carried over the ring-buffer read side
  typedef logic [7:0] byte_t;

  // FSM state encodings
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_req   = 3'd1;
  localparam logic [2:0] c_st_wait  = 3'd2;
  localparam logic [2:0] c_st_start = 3'd3;
  localparam logic [2:0] c_st_data  = 3'd4;
  localparam logic [2:0] c_st_stop  = 3'd5;

endpackage : uart_tx_drain_pkg
`default_nettype wire

// File: rtl/uart_tx_drain_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_drain_if
// Brief  : Read-side order/done handshake of the byte ring buffer.
//          master = consumer (issues order), slave = ring buffer.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_tx_drain_if;
  import uart_tx_drain_pkg::*;

  logic  buf_order;   // one-cycle pop request
  byte_t buf_data;    // popped byte, valid with buf_done
  logic  buf_done;    // pop completed, one cycle after order

  modport master (output buf_order, input buf_data, input buf_done);
  modport slave  (input buf_order, output buf_data, output buf_done);

endinterface : uart_tx_drain_if
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_tick
// Brief  : Bit-timing counter. Counts 0..CLK_PER_BIT-1 and wraps; tick marks
//          the last clock of a bit. clr holds the count at zero so each frame
//          starts on a fresh bit boundary.
// Rev    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLK_PER_BIT = 868,
  parameter int CNT_W       = 16
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic clr,
  output logic      tick
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free count within a frame, held at zero while cleared
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = !clr && (r_cnt == c_last);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_drain
// Brief  : Pops bytes from the ring buffer through the order/done handshake
//          and serialises each as an 8N1 frame on txd (LSB first, idle high).
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int CLK_PER_BIT = c_uart_clk_per_bit,
  parameter int CNT_W       = c_len_uart_cnt
) (
  input  wire logic         clk,
  input  wire logic         rstn,
  input  wire logic         en,
  uart_tx_drain_if.master   bus,
  output logic              txd,
  output logic              busy
);

  logic [2:0] r_state;
  byte_t      r_shift;
  logic [2:0] r_bit;
  logic       r_txd;
  logic       r_busy;
  logic       w_tick;
  logic       w_clr;

  // Timer only runs while a frame is on the line
  assign w_clr = (r_state != c_st_start) &&
                 (r_state != c_st_data)  &&
                 (r_state != c_st_stop);

  uart_baud_tick #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // Order is a pure decode of REQ, so it is high for exactly one cycle per pop
  assign bus.buf_order = (r_state == c_st_req);
  assign txd           = r_txd;
  assign busy          = r_busy;

  // Fetch / serialise state machine; txd is registered so each level lasts CLK_PER_BIT clocks
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= c_st_idle;
      r_shift <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_txd <= 1'b1;
          if (en) r_state <= c_st_req;
        end
        c_st_req: begin
          r_state <= c_st_wait;
        end
        c_st_wait: begin
          if (bus.buf_done) begin
            r_shift <= bus.buf_data;
            r_busy  <= 1'b1;
            r_txd   <= 1'b0;          // start bit begins next cycle
            r_state <= c_st_start;
          end else begin
            // Empty buffer: go straight back to REQ so polling runs every 2 cycles
            r_state <= en ? c_st_req : c_st_idle;
          end
        end
        c_st_start: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_bit   <= '0;
            r_state <= c_st_data;
          end
        end
        c_st_data: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= c_st_stop;
            end else begin
              r_txd <= r_shift[1];
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        c_st_stop: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= en ? c_st_req : c_st_idle;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule : uart_tx_drain
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_drain
// Brief  : Directed bench for uart_tx_drain with CLK_PER_BIT=4 and a ring
//          buffer model returning done one cycle after each order.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_drain;

  localparam int CPB = 4;

  logic clk;
  logic rstn;
  logic en;
  logic txd;
  logic busy;

  uart_tx_drain_if bif ();

  uart_tx_drain #(
    .CLK_PER_BIT (CPB),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .bus  (bif.master),
    .txd  (txd),
    .busy (busy)
  );

  int checks = 0;
  int passes = 0;
  int n_order = 0;
  int n_pop = 0;
  logic [7:0] q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring buffer model: registered done one cycle after an order, empty -> no done
  initial begin
    bif.buf_done = 1'b0;
    bif.buf_data = 8'h00;
  end
  always @(posedge clk) begin
    if (bif.buf_order) begin
      n_order <= n_order + 1;
      if (q.size() > 0) begin
        bif.buf_done <= 1'b1;
        bif.buf_data <= q.pop_front();
        n_pop        <= n_pop + 1;
      end else begin
        bif.buf_done <= 1'b0;
      end
    end else begin
      bif.buf_done <= 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance until the start bit appears; optionally require an exact gap
  task automatic wait_start(input int exp_gap, input string tag);
    int n = 0;
    while (txd !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk({31'd0, txd}, 32'd0, {tag, "_start_seen"});
    if (exp_gap >= 0) chk(n, exp_gap, {tag, "_gap"});
  endtask

  // Check txd/busy on frame cycles first..last (0 = first start-bit cycle)
  task automatic check_bits(input logic [7:0] b, input int first, input int last, input string tag);
    logic lvl;
    int   s;
    for (int c = first; c <= last; c++) begin
      s = c / CPB;
      if (s == 0)      lvl = 1'b0;
      else if (s == 9) lvl = 1'b1;
      else             lvl = b[s-1];
      chk({31'd0, txd}, {31'd0, lvl}, $sformatf("%s_txd_c%0d", tag, c));
      chk({31'd0, busy}, 32'd1, $sformatf("%s_busy_c%0d", tag, c));
      tick();
    end
  endtask

  initial begin
    int o0;
    int p0;
    rstn = 1'b0;
    en   = 1'b0;

    // 1: reset held 3 cycles, then idle with en=0
    repeat (3) tick();
    chk({31'd0, txd}, 32'd1, "rst_txd");
    chk({31'd0, busy}, 32'd0, "rst_busy");
    chk({31'd0, bif.buf_order}, 32'd0, "rst_order");
    rstn = 1'b1;
    repeat (10) tick();
    chk({31'd0, txd}, 32'd1, "idle_txd");
    chk({31'd0, busy}, 32'd0, "idle_busy");
    chk(n_order, 32'd0, "idle_no_order");

    // 2: single byte 0x55
    q.push_back(8'h55);
    en = 1'b1;
    wait_start(3, "b55");
    check_bits(8'h55, 0, 39, "b55");
    chk({31'd0, busy}, 32'd0, "b55_busy_drop");
    chk(n_pop, 32'd1, "b55_pops");
    chk(n_order, 32'd1, "b55_orders");
    chk({31'd0, bif.buf_order}, 32'd1, "b55_poll_resume");
    en = 1'b0;
    repeat (3) tick();

    // 3: empty buffer polling every 2 cycles
    o0 = n_order;
    p0 = n_pop;
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk({31'd0, bif.buf_order}, {31'd0, i[0]}, $sformatf("poll_order_%0d", i));
      chk({31'd0, txd}, 32'd1, $sformatf("poll_txd_%0d", i));
      chk({31'd0, busy}, 32'd0, $sformatf("poll_busy_%0d", i));
    end
    chk(n_order - o0, 32'd10, "poll_count");
    chk(n_pop - p0, 32'd0, "poll_no_pop");
    en = 1'b0;
    repeat (3) tick();

    // 4: back-to-back 0xA5, 0x3C with 6-cycle stop gap
    p0 = n_pop;
    q.push_back(8'hA5);
    q.push_back(8'h3C);
    en = 1'b1;
    wait_start(-1, "bA5");
    check_bits(8'hA5, 0, 39, "bA5");
    wait_start(2, "b3C");
    check_bits(8'h3C, 0, 39, "b3C");
    chk(n_pop - p0, 32'd2, "b2b_pops");
    en = 1'b0;
    repeat (3) tick();
    chk(n_pop - p0, 32'd2, "b2b_no_dup");

    // 5: reset during data bit 3 of 0xF0, then clean 0x81
    q.push_back(8'hF0);
    en = 1'b1;
    wait_start(-1, "bF0");
    check_bits(8'hF0, 0, 17, "bF0");
    rstn = 1'b0;
    tick();
    chk({31'd0, txd}, 32'd1, "midrst_txd");
    chk({31'd0, busy}, 32'd0, "midrst_busy");
    q.push_back(8'h81);
    tick();
    rstn = 1'b1;
    wait_start(3, "b81");
    check_bits(8'h81, 0, 39, "b81");
    en = 1'b0;
    repeat (3) tick();

    // 6: en dropped during start bit of 0x00
    q.push_back(8'h00);
    en = 1'b1;
    wait_start(-1, "b00");
    check_bits(8'h00, 0, 1, "b00");
    en = 1'b0;
    check_bits(8'h00, 2, 39, "b00");
    o0 = n_order;
    for (int i = 0; i < 10; i++) begin
      chk({31'd0, bif.buf_order}, 32'd0, $sformatf("endis_order_%0d", i));
      chk({31'd0, txd}, 32'd1, $sformatf("endis_txd_%0d", i));
      tick();
    end
    chk(n_order - o0, 32'd0, "endis_no_order");
    chk({31'd0, busy}, 32'd0, "endis_busy");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_uart_tx_drain
`default_nettype wire
